// File: rtl/cascade_tick_counter.sv
// -----------------------------------------------------------------------------
// cascade_tick_counter
//
// Purpose:
//   Two counters in one clock domain. The primary down-counter acts as a
//   prescaler. It reloads from the latched divide value at terminal count and
//   raises a one-cycle enable tick at that point. The secondary up-counter
//   advances on each tick. A run ends after the latched number of ticks. The
//   block then gives a one-cycle done pulse and goes back to idle.
//
//   A derived (divided) clock is never generated. The secondary counter uses
//   the tick as a clock enable, so every flop runs on clk.
//
// Optional feature (compile-time macro CASCADE_AUTORELOAD_EN):
//   When defined, DONE returns to RUN with the latched values, so runs repeat
//   until abort. When undefined, DONE always returns to IDLE, and b_count keeps
//   its final value there.
//
// Parameters:
//   WIDTH_A  width of the primary down-counter and of div_val
//   WIDTH_B  width of the secondary up-counter and of term_val
//
// Ports:
//   clk          in   system clock, rising-edge active
//   reset        in   synchronous active-high reset
//   start_valid  in   start request, accepted only while start_ready is high
//   start_ready  out  high only in IDLE
//   div_val      in   primary reload value; tick period is div_val+1 cycles
//   term_val     in   ticks per run; 0 means 2^WIDTH_B ticks
//   abort        in   cancel the run (RUN/DONE); ignored in IDLE
//   a_count      out  current primary (down) count
//   b_count      out  current secondary (up) count
//   tick         out  one-cycle enable at primary terminal count
//   busy         out  high in RUN or DONE
//   done         out  one-cycle pulse when a run completes
// -----------------------------------------------------------------------------
module cascade_tick_counter #(
  parameter int WIDTH_A = 4,
  parameter int WIDTH_B = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [WIDTH_A-1:0] div_val,
  input  logic [WIDTH_B-1:0] term_val,
  input  logic               abort,
  output logic [WIDTH_A-1:0] a_count,
  output logic [WIDTH_B-1:0] b_count,
  output logic               tick,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH_A-1:0] A_ZERO = {WIDTH_A{1'b0}};
  localparam logic [WIDTH_A-1:0] A_ONE  = {{(WIDTH_A-1){1'b0}}, 1'b1};
  localparam logic [WIDTH_B-1:0] B_ZERO = {WIDTH_B{1'b0}};
  localparam logic [WIDTH_B-1:0] B_ONE  = {{(WIDTH_B-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [WIDTH_A-1:0] a_q, a_d;
  logic [WIDTH_B-1:0] b_q, b_d;
  logic [WIDTH_A-1:0] div_q, div_d;
  logic [WIDTH_B-1:0] term_q, term_d;

  logic               a_at_zero_s;
  logic [WIDTH_B-1:0] b_inc_s;

  assign a_at_zero_s = (a_q == A_ZERO);
  // This wraps modulo 2^WIDTH_B. With term_q == 0, the run therefore ends
  // after 2^WIDTH_B ticks and no special case is needed.
  assign b_inc_s     = b_q + B_ONE;

  // These outputs are decoded from registered state only, so they have no
  // combinational path from the inputs.
  assign start_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign tick        = (state_q == ST_RUN) && a_at_zero_s;
  assign a_count     = a_q;
  assign b_count     = b_q;

  // State and counter registers; synchronous reset has highest priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= A_ZERO;
      b_q     <= B_ZERO;
      div_q   <= A_ZERO;
      term_q  <= B_ZERO;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      div_q   <= div_d;
      term_q  <= term_d;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    div_d   = div_q;
    term_d  = term_q;

    case (state_q)
      ST_IDLE: begin
        // abort is ignored here, so start wins when both are present.
        if (start_valid) begin
          div_d   = div_val;
          term_d  = term_val;
          a_d     = div_val;
          b_d     = B_ZERO;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (abort) begin
          // abort overrides terminal detection on the final tick.
          state_d = ST_IDLE;
          a_d     = A_ZERO;
          b_d     = B_ZERO;
        end else if (!a_at_zero_s) begin
          a_d = a_q - A_ONE;
        end else begin
          a_d = div_q;
          b_d = b_inc_s;
          if (b_inc_s == term_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_DONE: begin
        if (abort) begin
          state_d = ST_IDLE;
          a_d     = A_ZERO;
          b_d     = B_ZERO;
        end else begin
`ifdef CASCADE_AUTORELOAD_EN
          state_d = ST_RUN;
          a_d     = div_q;
          b_d     = B_ZERO;
`else
          state_d = ST_IDLE;
`endif
        end
      end

      default: begin
        // Recover from any unreachable encoding.
        state_d = ST_IDLE;
        a_d     = A_ZERO;
        b_d     = B_ZERO;
      end
    endcase
  end

endmodule

// File: tb/tb_cascade_tick_counter.sv
// -----------------------------------------------------------------------------
// tb_cascade_tick_counter
//
// Directed self-checking bench for cascade_tick_counter with the default
// widths (4/4). The expected values below are computed by hand from the
// counter behaviour. Inputs change 1 ns after a rising edge, and the outputs
// are sampled at that same time.
// -----------------------------------------------------------------------------
module tb_cascade_tick_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_valid;
  logic       start_ready;
  logic [3:0] div_val;
  logic [3:0] term_val;
  logic       abort;
  logic [3:0] a_count;
  logic [3:0] b_count;
  logic       tick;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  cascade_tick_counter #(.WIDTH_A(4), .WIDTH_B(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .div_val     (div_val),
    .term_val    (term_val),
    .abort       (abort),
    .a_count     (a_count),
    .b_count     (b_count),
    .tick        (tick),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue a one-cycle start request; returns in RUN cycle 1.
  task automatic start_run(input logic [3:0] d, input logic [3:0] t);
    div_val     = d;
    term_val    = t;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_valid = 1'b0; abort = 1'b0;
    div_val = 4'd0; term_val = 4'd0;

    // Reset for 2 cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      start_valid = 1'($urandom);
      abort       = 1'($urandom);
      div_val     = 4'($urandom);
      term_val    = 4'($urandom);
      step();
    end
    chk("rst_a", a_count, 0);
    chk("rst_b", b_count, 0);
    chk("rst_tick", tick, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", start_ready, 1);
    reset = 1'b0; start_valid = 1'b0; abort = 1'b0;
    step();

`ifndef CASCADE_AUTORELOAD_EN
    // Basic run: div=2, term=3.
    start_run(4'd2, 4'd3);
    for (int c = 1; c <= 9; c++) begin
      chk($sformatf("basic_a_c%0d", c), a_count, 2 - ((c - 1) % 3));
      chk($sformatf("basic_b_c%0d", c), b_count, (c - 1) / 3);
      chk($sformatf("basic_tick_c%0d", c), tick, (c % 3 == 0) ? 1 : 0);
      chk($sformatf("basic_done_c%0d", c), done, 0);
      chk($sformatf("basic_ready_c%0d", c), start_ready, 0);
      step();
    end
    chk("basic_done_c10", done, 1);
    chk("basic_b_c10", b_count, 3);
    chk("basic_tick_c10", tick, 0);
    chk("basic_busy_c10", busy, 1);
    step();
    chk("basic_busy_c11", busy, 0);
    chk("basic_ready_c11", start_ready, 1);
    chk("basic_b_c11", b_count, 3);
    chk("basic_a_c11", a_count, 2);
    chk("basic_done_c11", done, 0);
    step();
    chk("basic_single_done", done, 0);
    chk("basic_b_hold", b_count, 3);

    // div=0, term=0: tick every cycle for 16 cycles, b wraps to 0.
    start_run(4'd0, 4'd0);
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("d0_tick_c%0d", c), tick, 1);
      chk($sformatf("d0_b_c%0d", c), b_count, (c - 1) % 16);
      chk($sformatf("d0_done_c%0d", c), done, 0);
      step();
    end
    chk("d0_done_c17", done, 1);
    chk("d0_b_c17", b_count, 0);
    step();
    chk("d0_idle", busy, 0);

    // div=15, term=1: single tick at RUN cycle 16.
    start_run(4'd15, 4'd1);
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("d15_tick_c%0d", c), tick, (c == 16) ? 1 : 0);
      chk($sformatf("d15_a_c%0d", c), a_count, 16 - c);
      step();
    end
    chk("d15_done_c17", done, 1);
    chk("d15_b_c17", b_count, 1);
    step();
    chk("d15_idle", busy, 0);

    // start_valid and abort together in IDLE: start is accepted.
    div_val = 4'd1; term_val = 4'd1; abort = 1'b1; start_valid = 1'b1;
    step();
    abort = 1'b0; start_valid = 1'b0;
    chk("sa_busy", busy, 1);
    chk("sa_a", a_count, 1);
    step();
    chk("sa_tick", tick, 1);
    step();
    chk("sa_done", done, 1);
    step();
    chk("sa_idle", busy, 0);
`endif

    // Abort mid-run: div=3, term=4; an ignored start in RUN.
    start_run(4'd3, 4'd4);
    step();                                   // RUN cycle 2
    div_val = 4'd9; term_val = 4'd9; start_valid = 1'b1;
    step();                                   // RUN cycle 3
    start_valid = 1'b0;
    chk("ab_ignored_start_a", a_count, 1);
    chk("ab_ignored_start_busy", busy, 1);
    step();                                   // cycle 4
    chk("ab_tick_c4", tick, 1);
    step(); step();                           // cycle 6
    chk("ab_a_c6", a_count, 2);
    chk("ab_b_c6", b_count, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_idle", busy, 0);
    chk("ab_a", a_count, 0);
    chk("ab_b", b_count, 0);
    chk("ab_done", done, 0);
    step();
    chk("ab_no_done", done, 0);

    // Abort on the final tick: div=1, term=2; final tick at RUN cycle 4.
    start_run(4'd1, 4'd2);
    step(); step(); step();                   // cycle 4
    chk("at_tick_c4", tick, 1);
    chk("at_b_c4", b_count, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("at_idle", busy, 0);
    chk("at_done", done, 0);
    chk("at_b", b_count, 0);
    step();
    chk("at_no_done", done, 0);

    // Reset mid-run clears everything.
    start_run(4'd3, 4'd4);
    step(); step(); step(); step();           // cycle 5: a=3, b=1
    chk("rm_b_pre", b_count, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rm_busy", busy, 0);
    chk("rm_a", a_count, 0);
    chk("rm_b", b_count, 0);

    // Reset in the same cycle as start_valid: the start is not taken.
    reset = 1'b1; start_valid = 1'b1; div_val = 4'd5; term_val = 4'd2;
    step();
    reset = 1'b0; start_valid = 1'b0;
    chk("rs_busy", busy, 0);
    chk("rs_a", a_count, 0);
    step();
    chk("rs_still_idle", busy, 0);

`ifdef CASCADE_AUTORELOAD_EN
    // Auto-reload: div=1, term=2; done every 5 cycles and start_ready stays 0.
    start_run(4'd1, 4'd2);
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("ar_done_c%0d", c), done, (c % 5 == 0) ? 1 : 0);
      chk($sformatf("ar_ready_c%0d", c), start_ready, 0);
      if (c == 6) begin
        chk("ar_b_c6", b_count, 0);
        chk("ar_a_c6", a_count, 1);
      end
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ar_abort_idle", busy, 0);
    chk("ar_abort_ready", start_ready, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cascade_tick_counter.md
Name: cascade_tick_counter

Overview:
Single-clock cascaded counter pair. A primary down-counter (prescaler) reloads at terminal count and issues a one-cycle enable tick. A secondary up-counter advances on each tick. It replaces derived-clock cascading with a clock-enable scheme, so the whole block sits in one clock domain. A start handshake loads the divide and terminal values; the block reports completion with a one-cycle done pulse.

Parameters:
WIDTH_A, 4, width of primary down-counter and divide value
WIDTH_B, 4, width of secondary up-counter and terminal value

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
start_valid  input  1  request to begin a run; qualified by start_ready
start_ready  output  1  block can accept a start; high only in IDLE
div_val  input  WIDTH_A  primary reload value; tick period = div_val+1 cycles
term_val  input  WIDTH_B  tick count per run; 0 means 2^WIDTH_B ticks
abort  input  1  cancel the current run
a_count  output  WIDTH_A  current primary (down) count
b_count  output  WIDTH_B  current secondary (up) count
tick  output  1  one-cycle enable pulse at primary terminal count
busy  output  1  high in RUN or DONE
done  output  1  one-cycle pulse when the run completes

Behaviour:
- FSM states: IDLE, RUN, DONE. All state and counters are registered on the rising edge of clk.
- Reset (synchronous, highest priority) sets state=IDLE, a_count=0, b_count=0, div_reg=0, term_reg=0.
- Combinational outputs:
  - start_ready = (state==IDLE)
  - busy = (state!=IDLE)
  - done = (state==DONE)
  - tick = (state==RUN && a_count==0)
- IDLE:
  - On start_valid && start_ready: div_reg<=div_val, term_reg<=term_val, a_count<=div_val, b_count<=0, go to RUN.
  - Otherwise a_count and b_count hold their last values.
- RUN, a_count!=0: a_count<=a_count-1.
- RUN, a_count==0 (tick cycle):
  - a_count<=div_reg, b_count<=b_count+1 (mod 2^WIDTH_B).
  - If b_count+1 == term_reg (mod 2^WIDTH_B), go to DONE.
- DONE: lasts exactly one cycle, with counters holding. Next state is IDLE, or RUN under the optional feature.
- Run length = (div_reg+1)*N cycles in RUN, where N = term_reg, or 2^WIDTH_B when term_reg==0.
- div_val=0: tick is high every RUN cycle.
- abort in RUN or DONE: next state IDLE, a_count<=0, b_count<=0. No done pulse is issued. abort takes priority over terminal detection and the DONE transition. abort in IDLE is ignored.
- start_valid while not in IDLE is ignored; no buffering.
- start_valid and abort together in IDLE: start is accepted.
- Reset asserted mid-run: the next cycle is IDLE with all counters cleared. Any pending done is lost.

Optional Feature:
Macro: CASCADE_AUTORELOAD_EN
- Defined: from DONE, unless abort is high, the block returns to RUN with a_count<=div_reg, b_count<=0, repeating the run with the latched values. start_ready stays low until abort returns the block to IDLE. done pulses once per completed run.
- Undefined: DONE always goes to IDLE, and b_count holds its final value there.

Test Plan:
- Reset: assert reset 2 cycles with random inputs -> a_count=0, b_count=0, tick=0, done=0, busy=0, start_ready=1.
- Basic run: start with div_val=2, term_val=3 ->
  - a_count sequence 2,1,0 repeated; tick on RUN cycles 3, 6, 9; b_count 1,2,3.
  - done=1 on cycle 10, IDLE on cycle 11 with b_count=3.
- Boundaries:
  - div_val=0, term_val=0 -> tick on every cycle for 16 cycles, b_count wraps to 0, done on cycle 17.
  - div_val=15, term_val=1 -> single tick at cycle 16.
- Abort: start with div=3, term=4, pulse abort on RUN cycle 6 -> next cycle IDLE, a_count=0, b_count=0, no done. A start_valid issued in RUN is ignored.
- Abort vs terminal: assert abort on the final tick cycle -> IDLE, no done pulse. Reset on the same cycle as a start_valid -> IDLE, start not taken.
- CASCADE_AUTORELOAD_EN defined, div=1, term=2 -> done pulses every 5 cycles (4 RUN + 1 DONE) and start_ready stays 0. abort -> IDLE. Macro undefined -> a single done pulse only.
